sram22_cfg_model: RTL and testbench
===================================

// Module: sram22_cfg_model
// PURPOSE
//  Parametrised behavioural model of an SRAM22 single-port macro: configurable width, depth and mask
//  granularity, 1- or 2-cycle read latency, selectable write-through, and a reset-time clear sequencer.
//  Drop-in for sky130 macro wrappers in RTL simulation and FPGA prototyping. Reports readiness and
//  read-data validity to the surrounding controller.
// PARAMETERS
//  DATA_WIDTH    32  word width in bits
//  ADDR_WIDTH    9   address bits; RAM_DEPTH = 1<<ADDR_WIDTH
//  MASK_GRAN     8   bits per wmask lane; WMASK_WIDTH = DATA_WIDTH/MASK_GRAN (DATA_WIDTH%MASK_GRAN==0, else elaboration error)
//  READ_LATENCY  1   1 or 2 clk edges from accepted read to dout (other values: elaboration error)
//  WRITE_THROUGH 0   1: a write also returns the merged word on dout; 0: writes leave dout unchanged
//  CLEAR_ON_RST  1   1: zero every word after reset release; 0: contents untouched, ready one cycle after release
// PORTS
//  clk         in   1             clock, all state on rising edge
//  rstb        in   1             asynchronous active-low reset
//  ce          in   1             chip enable; access accepted when ce && ready
//  we          in   1             1 write, 0 read
//  wmask       in   WMASK_WIDTH   per-lane write enable, lane i = bits [i*MASK_GRAN +: MASK_GRAN]
//  addr        in   ADDR_WIDTH    word address
//  din         in   DATA_WIDTH    write data
//  dout        out  DATA_WIDTH    read data, held between reads
//  dout_valid  out  1             1-cycle pulse when dout carries new data
//  ready       out  1             1 = accesses accepted; 0 during clear sweep
// BEHAVIOUR
//  Reset (rstb=0, async): dout=0, dout_valid=0, ready=0, clr_addr=0, read pipeline flushed, FSM->CLEAR
//   (CLEAR_ON_RST=1) or WAIT (CLEAR_ON_RST=0). Memory contents are not reset by rstb itself.
//  FSM CLEAR: each clk writes 0 to mem[clr_addr], clr_addr++; after writing RAM_DEPTH-1 -> READY.
//   ready rises on the edge that writes the last word: first accepted access is RAM_DEPTH+1 edges after release.
//  FSM WAIT: one edge -> READY. READY: ready=1, stays until rstb=0.
//  Accesses with ce=1 while ready=0 are dropped silently: no write, no dout change, no dout_valid.
//  Write (ce&&we&&ready): at the edge, each lane with wmask[i]=1 takes din lane; other lanes keep old data.
//   wmask all zero = no memory change. WRITE_THROUGH=1: merged word enters read pipeline as a read would.
//  Read (ce&&!we&&ready): mem[addr] sampled at accept edge.
//   READ_LATENCY=1: dout/dout_valid updated at accept edge. READ_LATENCY=2: one extra register stage,
//   dout/dout_valid updated on following edge. Back-to-back reads give one result per cycle.
//  Read-after-write same addr, next cycle: read returns new data. Write after read in pipeline (LAT=2):
//   in-flight read returns data sampled at its own accept edge (old data).
//  dout holds value when no result emerges; dout_valid=0 those cycles.
//  rstb asserted mid-sweep or with a read in flight: in-flight result discarded (no dout_valid), sweep
//   restarts from address 0 on release.
//  addr is always in range (full power-of-two depth); no wrap handling needed.
// TESTING
//  T1 reset/clear: write 0xDEADBEEF @0x1FF, pulse rstb, release -> ready=0 for 512 edges, then read
//     0x1FF -> dout=0x00000000, dout_valid 1 cycle.
//  T2 masked write: write 0x11223344 @0x010 mask 4'hF, then 0xAABBCCDD mask 4'b0101 -> read = 0x11BB33DD.
//  T3 latency: READ_LATENCY=2, reads @1,@2,@3 back-to-back -> dout_valid high 3 consecutive cycles,
//     starting 2 edges after first accept, data in order.
//  T4 write-through: WRITE_THROUGH=1, mem[0x020]=0x01020304, write 0xFFFFFFFF mask 4'b1000 -> dout=0xFF020304,
//     dout_valid pulse; WRITE_THROUGH=0 same stimulus -> dout unchanged, no pulse.
//  T5 not-ready drop: ce=1 we=1 at sweep cycle 10 @0x100 -> after sweep, read 0x100 = 0, no dout_valid during sweep.
//  T6 reset mid-read: LAT=2, accept read then rstb=0 before second edge -> dout=0, dout_valid never pulses;
//     sweep restarts at 0 (ready after 512 edges).

Source files
------------

// File: rtl/sram22_cfg_model.sv
// sram22_cfg_model: behavioural single-port SRAM macro model.
// Configurable width, depth and mask granularity; 1- or 2-cycle read latency;
// optional write-through; optional zeroing sweep after reset release.
module sram22_cfg_model #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 9,
    parameter int MASK_GRAN     = 8,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_THROUGH = 0,
    parameter int CLEAR_ON_RST  = 1,
    localparam int WMASK_WIDTH  = DATA_WIDTH / MASK_GRAN
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   ce,
    input  logic                   we,
    input  logic [WMASK_WIDTH-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]  addr,
    input  logic [DATA_WIDTH-1:0]  din,
    output logic [DATA_WIDTH-1:0]  dout,
    output logic                   dout_valid,
    output logic                   ready
);

    localparam int RAM_DEPTH = 1 << ADDR_WIDTH;

    // Reject unsupported configurations at elaboration time.
    if ((DATA_WIDTH % MASK_GRAN) != 0) begin : g_bad_gran
        $error("sram22_cfg_model: DATA_WIDTH must be a multiple of MASK_GRAN");
    end
    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_lat
        $error("sram22_cfg_model: READ_LATENCY must be 1 or 2");
    end

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_WAIT,
        ST_READY
    } state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clr_addr_reg;
    logic                    ready_reg;
    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic [DATA_WIDTH-1:0]   bit_mask;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic                    accept_wr;
    logic                    accept_rd;
    logic                    clear_en;
    logic                    res_valid;
    logic [DATA_WIDTH-1:0]   res_data;

    // Expand each wmask lane bit to a full lane of bit enables.
    for (genvar gi = 0; gi < WMASK_WIDTH; gi++) begin : g_lane
        assign bit_mask[gi*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{wmask[gi]}};
    end

    assign accept_wr   = ce && we && ready_reg;
    assign accept_rd   = ce && !we && ready_reg;
    // The sweep is gated by rstb so that edges seen while held in reset
    // do not keep rewriting word 0.
    assign clear_en    = (state_reg == ST_CLEAR) && rstb;
    assign old_word    = mem[addr];
    assign merged_word = (old_word & ~bit_mask) | (din & bit_mask);

    // A result enters the read path on a read, or on a write when write-through is on.
    assign res_valid = accept_rd || ((WRITE_THROUGH != 0) && accept_wr);
    assign res_data  = we ? merged_word : old_word;

    // Memory array: the clear sweep has priority, otherwise a masked user write.
    always_ff @(posedge clk) begin
        if (clear_en) begin
            mem[clr_addr_reg] <= '0;
        end else if (accept_wr) begin
            mem[addr] <= merged_word;
        end
    end

    // Readiness FSM: sweep every word (or wait one edge), then stay ready.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_reg    <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_WAIT;
            clr_addr_reg <= '0;
            ready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_reg <= ST_READY;
                        ready_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    state_reg <= ST_READY;
                    ready_reg <= 1'b1;
                end
                default: begin
                    ready_reg <= 1'b1;
                end
            endcase
        end
    end

    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  dout_valid_reg;

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] p1_data_reg;
        logic                  p1_valid_reg;

        // Two-stage read path: the sampled word waits one extra edge before dout.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                p1_data_reg    <= '0;
                p1_valid_reg   <= 1'b0;
                dout_reg       <= '0;
                dout_valid_reg <= 1'b0;
            end else begin
                p1_valid_reg   <= res_valid;
                dout_valid_reg <= p1_valid_reg;
                if (res_valid) begin
                    p1_data_reg <= res_data;
                end
                if (p1_valid_reg) begin
                    dout_reg <= p1_data_reg;
                end
            end
        end
    end else begin : g_lat1
        // Single-stage read path: dout updates on the accept edge and holds otherwise.
        always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
                dout_reg       <= '0;
                dout_valid_reg <= 1'b0;
            end else begin
                dout_valid_reg <= res_valid;
                if (res_valid) begin
                    dout_reg <= res_data;
                end
            end
        end
    end

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign ready      = ready_reg;

endmodule

// File: tb/tb_sram22_cfg_model.sv
// Directed bench for sram22_cfg_model. Three instances share one stimulus:
//   a: latency 1, no write-through, clear on reset
//   b: latency 2, write-through,    clear on reset
//   c: latency 1, no write-through, no clear (ready one edge after release)
module tb_sram22_cfg_model;

    logic        clk;
    logic        rstb;
    logic        ce;
    logic        we;
    logic [3:0]  wmask;
    logic [8:0]  addr;
    logic [31:0] din;

    logic [31:0] dout_a, dout_b, dout_c;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;

    int n_checks = 0;
    int n_errors = 0;

    sram22_cfg_model #(.READ_LATENCY(1), .WRITE_THROUGH(0), .CLEAR_ON_RST(1)) dut_a (
        .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_a), .dout_valid(valid_a), .ready(ready_a)
    );

    sram22_cfg_model #(.READ_LATENCY(2), .WRITE_THROUGH(1), .CLEAR_ON_RST(1)) dut_b (
        .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_b), .dout_valid(valid_b), .ready(ready_b)
    );

    sram22_cfg_model #(.READ_LATENCY(1), .WRITE_THROUGH(0), .CLEAR_ON_RST(0)) dut_c (
        .clk(clk), .rstb(rstb), .ce(ce), .we(we), .wmask(wmask), .addr(addr), .din(din),
        .dout(dout_c), .dout_valid(valid_c), .ready(ready_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s %h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ce    = 1'b0;
        we    = 1'b0;
        wmask = 4'h0;
        addr  = '0;
        din   = '0;
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d, input logic [3:0] m);
        ce = 1'b1; we = 1'b1; addr = a; din = d; wmask = m;
        tick();
        idle_inputs();
    endtask

    // Read one word; instance a shows it on the accept edge, instance b one edge later.
    task automatic rd_check(input string tag, input logic [8:0] a, input logic [31:0] exp);
        ce = 1'b1; we = 1'b0; addr = a;
        tick();
        chk({tag, "_a_dout"}, dout_a, exp);
        chk({tag, "_a_valid"}, {31'b0, valid_a}, 32'd1);
        idle_inputs();
        tick();
        chk({tag, "_b_dout"}, dout_b, exp);
        chk({tag, "_b_valid"}, {31'b0, valid_b}, 32'd1);
        chk({tag, "_a_valid_off"}, {31'b0, valid_a}, 32'd0);
    endtask

    // Assert reset, check the reset state, release just after a rising edge.
    task automatic do_reset(input string tag);
        idle_inputs();
        rstb = 1'b0;
        #1;
        chk({tag, "_rst_dout_a"}, dout_a, 32'h0);
        chk({tag, "_rst_dout_b"}, dout_b, 32'h0);
        chk({tag, "_rst_valid"}, {30'b0, valid_a, valid_b}, 32'h0);
        chk({tag, "_rst_ready"}, {29'b0, ready_a, ready_b, ready_c}, 32'h0);
        tick();
        tick();
        rstb = 1'b1;
    endtask

    // Count edges until ready; optionally try a write then a read during the sweep.
    task automatic sweep(input string tag, input int inj);
        int n = 0;
        int viol = 0;
        chk({tag, "_c_ready_pre"}, {31'b0, ready_c}, 32'd0);
        while (!ready_a && n < 600) begin
            if (inj >= 0 && n == inj) begin
                ce = 1'b1; we = 1'b1; addr = 9'h100; din = 32'hFFFF_FFFF; wmask = 4'hF;
            end else if (inj >= 0 && n == inj + 1) begin
                ce = 1'b1; we = 1'b0; addr = 9'h100;
            end else begin
                idle_inputs();
            end
            tick();
            n++;
            if (n == 1) chk({tag, "_c_ready_1edge"}, {31'b0, ready_c}, 32'd1);
            if (valid_a || valid_b) viol++;
        end
        idle_inputs();
        chk({tag, "_sweep_edges"}, n, 32'd512);
        chk({tag, "_b_ready"}, {31'b0, ready_b}, 32'd1);
        chk({tag, "_no_valid_sweep"}, viol, 32'd0);
    endtask

    logic [31:0] t3_exp [3];

    initial begin
        int viol;
        t3_exp[0] = 32'h0000_00A1;
        t3_exp[1] = 32'h0000_00A2;
        t3_exp[2] = 32'h0000_00A3;
        idle_inputs();
        rstb = 1'b1;
        #3;
        do_reset("init");
        sweep("init", -1);

        // T1: cleared after reset
        wr(9'h1FF, 32'hDEAD_BEEF, 4'hF);
        rd_check("t1_pre", 9'h1FF, 32'hDEAD_BEEF);
        do_reset("t1");
        sweep("t1", -1);
        rd_check("t1_clr", 9'h1FF, 32'h0);

        // T2: masked write, read immediately after write; lowest address
        wr(9'h010, 32'h1122_3344, 4'hF);
        wr(9'h010, 32'hAABB_CCDD, 4'b0101);
        rd_check("t2_mask", 9'h010, 32'h11BB_33DD);
        wr(9'h000, 32'hCAFE_F00D, 4'hF);
        rd_check("t2_addr0", 9'h000, 32'hCAFE_F00D);

        // T3: back-to-back reads
        wr(9'h001, 32'hA1, 4'hF);
        wr(9'h002, 32'hA2, 4'hF);
        wr(9'h003, 32'hA3, 4'hF);
        tick();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                ce = 1'b1; we = 1'b0; addr = 9'(i + 1);
            end else begin
                idle_inputs();
            end
            tick();
            if (i < 3) begin
                chk($sformatf("t3_a_dout%0d", i), dout_a, t3_exp[i]);
                chk($sformatf("t3_a_valid%0d", i), {31'b0, valid_a}, 32'd1);
            end else begin
                chk($sformatf("t3_a_valid%0d", i), {31'b0, valid_a}, 32'd0);
            end
            if (i >= 1 && i <= 3) begin
                chk($sformatf("t3_b_dout%0d", i), dout_b, t3_exp[i-1]);
                chk($sformatf("t3_b_valid%0d", i), {31'b0, valid_b}, 32'd1);
            end else begin
                chk($sformatf("t3_b_valid%0d", i), {31'b0, valid_b}, 32'd0);
            end
        end

        // Write behind an in-flight latency-2 read: read returns old data
        ce = 1'b1; we = 1'b0; addr = 9'h001;
        tick();
        ce = 1'b1; we = 1'b1; addr = 9'h001; din = 32'hB1; wmask = 4'hF;
        tick();
        chk("war_b_old", dout_b, 32'hA1);
        chk("war_b_valid", {31'b0, valid_b}, 32'd1);
        chk("war_a_valid", {31'b0, valid_a}, 32'd0);
        idle_inputs();
        tick();
        chk("war_b_wt", dout_b, 32'hB1);
        rd_check("war_new", 9'h001, 32'hB1);

        // T4: write-through vs not
        wr(9'h020, 32'h0102_0304, 4'hF);
        rd_check("t4_pre", 9'h020, 32'h0102_0304);
        ce = 1'b1; we = 1'b1; addr = 9'h020; din = 32'hFFFF_FFFF; wmask = 4'b1000;
        tick();
        chk("t4_a_hold", dout_a, 32'h0102_0304);
        chk("t4_a_nopulse", {31'b0, valid_a}, 32'd0);
        chk("t4_b_wait", {31'b0, valid_b}, 32'd0);
        idle_inputs();
        tick();
        chk("t4_b_wt", dout_b, 32'hFF02_0304);
        chk("t4_b_pulse", {31'b0, valid_b}, 32'd1);
        chk("t4_a_nopulse2", {31'b0, valid_a}, 32'd0);
        wr(9'h020, 32'h1234_5678, 4'h0);
        rd_check("t4_mask0", 9'h020, 32'hFF02_0304);

        // T5: accesses during sweep are dropped
        wr(9'h100, 32'h0BAD_0BAD, 4'hF);
        do_reset("t5");
        sweep("t5", 10);
        rd_check("t5_drop", 9'h100, 32'h0);

        // T6: reset with a read in flight, then reset mid-sweep
        wr(9'h001, 32'h55AA_55AA, 4'hF);
        tick();
        ce = 1'b1; we = 1'b0; addr = 9'h001;
        tick();
        idle_inputs();
        #2;
        rstb = 1'b0;
        #1;
        chk("t6_b_dout", dout_b, 32'h0);
        chk("t6_b_valid", {31'b0, valid_b}, 32'd0);
        chk("t6_a_dout", dout_a, 32'h0);
        chk("t6_ready", {31'b0, ready_a}, 32'd0);
        tick();
        tick();
        rstb = 1'b1;
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid_a || valid_b || ready_a) viol++;
        end
        chk("t6_flushed", viol, 32'd0);
        do_reset("t6");
        sweep("t6", -1);
        rd_check("t6_clr", 9'h001, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
